count_capture: RTL

Timestamp-capture stage directly downstream of the free-running 8-bit counter. Samples the counter value on each rising edge of an event input and queues the timestamps in a small FIFO. A valid/ready interface presents them to a consumer. A sticky overflow flag records events lost while the queue is full.

---
 rtl/count_capture_pkg.sv | 16 +
 rtl/cc_sync_fifo.sv | 76 +++++++
 rtl/count_capture.sv | 91 +++++++++
 3 files changed

// File: rtl/count_capture_pkg.sv
// rtl/count_capture_pkg.sv - shared defaults and width helpers for the count_capture stage
package count_capture_pkg;

  localparam int CC_WIDTH_DEFAULT = 8;
  localparam int CC_DEPTH_DEFAULT = 4;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit more than the pointers.
  function automatic int cc_level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cc_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cc_sync_fifo.sv
// rtl/cc_sync_fifo.sv - single-clock show-ahead FIFO with push/pop/clear and occupancy count
module cc_sync_fifo
  import count_capture_pkg::*;
#(
  parameter int WIDTH = CC_WIDTH_DEFAULT,
  parameter int DEPTH = CC_DEPTH_DEFAULT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear_i,
  input  logic                              push_i,
  input  logic [WIDTH-1:0]                  push_data_i,
  input  logic                              pop_i,
  output logic [WIDTH-1:0]                  head_data_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [cc_level_width(DEPTH)-1:0]  level_o
);

  localparam int AW = cc_ptr_width(DEPTH);
  localparam int LW = cc_level_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign head_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !clear_i && do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/count_capture.sv
// rtl/count_capture.sv - trigger-edge timestamp capture into a FIFO; COUNT_CAPTURE_DELTA_EN stores deltas
module count_capture
  import count_capture_pkg::*;
#(
  parameter int WIDTH = CC_WIDTH_DEFAULT,
  parameter int DEPTH = CC_DEPTH_DEFAULT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [WIDTH-1:0]                  count_i,
  input  logic                              trig_i,
  input  logic                              clear_i,
  output logic [WIDTH-1:0]                  cap_data_o,
  output logic                              cap_valid_o,
  input  logic                              cap_ready_i,
  output logic                              overflow_o,
  output logic [cc_level_width(DEPTH)-1:0]  level_o
);

  logic             trig_q;
  logic             overflow_q, overflow_d;
  logic             cap_edge;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             drop;
  logic [WIDTH-1:0] store_data;

  assign cap_edge = trig_i & ~trig_q;
  assign pop      = cap_valid_o & cap_ready_i;

  // Clear wins over everything, so an edge in the clear cycle is neither stored nor dropped.
  assign accept = cap_edge & ~clear_i & (~fifo_full | pop);
  assign drop   = cap_edge & ~clear_i & fifo_full & ~pop;

`ifdef COUNT_CAPTURE_DELTA_EN
  logic [WIDTH-1:0] base_q, base_d;

  assign store_data = count_i - base_q;

  always_comb begin
    base_d = base_q;
    if (clear_i)     base_d = '0;
    else if (accept) base_d = count_i;
  end

  always_ff @(posedge clk) begin
    if (reset) base_q <= '0;
    else       base_q <= base_d;
  end
`else
  assign store_data = count_i;
`endif

  always_comb begin
    overflow_d = overflow_q;
    if (clear_i)   overflow_d = 1'b0;
    else if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      trig_q     <= trig_i;
      overflow_q <= overflow_d;
    end
  end

  cc_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (clear_i),
    .push_i      (accept),
    .push_data_i (store_data),
    .pop_i       (pop),
    .head_data_o (cap_data_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level_o)
  );

  assign cap_valid_o = ~fifo_empty;
  assign overflow_o  = overflow_q;

endmodule
